// File: rtl/alarm_pkg.sv
// ============================================================================
// alarm_pkg : shared state encodings, timer width and zone masks for the
//             alarm controller.
// Rev 1.0
// ============================================================================
`default_nettype none

package alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4
  } state_t;

  localparam int         c_TIMER_W      = 8;
  localparam logic [3:0] c_ZONE_DELAYED = 4'b0001;
  localparam logic [3:0] c_ZONE_INSTANT = 4'b1110;

  // Counter expires at zero, so N cycles in a state needs a load of N-1.
  function automatic logic [c_TIMER_W-1:0] timer_load(input int unsigned cycles);
    logic [31:0] w_m1;
    w_m1 = cycles - 32'd1;
    return w_m1[c_TIMER_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_timer.sv
// ============================================================================
// alarm_timer : 8-bit down-counter, loadable, saturating at zero.
// Rev 1.0
// ============================================================================
`default_nettype none

module alarm_timer
  import alarm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [c_TIMER_W-1:0] i_load_val,
  output logic                 o_expired
);

  logic [c_TIMER_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/alarm_controller.sv
// ============================================================================
// alarm_controller : intruder-alarm FSM with exit/entry delays, siren timeout
//                    and zone latch. Optional door chime via ALARM_CHIME_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module alarm_controller
  import alarm_pkg::*;
#(
  parameter int unsigned EXIT_DLY  = 16,
  parameter int unsigned ENTRY_DLY = 8,
  parameter int unsigned SIREN_TO  = 64
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [3:0] Sensor,
  input  logic       Arm_Req,
  input  logic       Disarm_Req,
  output logic       Alarm_State,
  output logic       Armed,
  output logic [2:0] State,
  output logic [3:0] Latched_Zone,
  output logic       Arm_Fault
`ifdef ALARM_CHIME_EN
  ,
  output logic       Chime
`endif
);

  localparam logic [c_TIMER_W-1:0] c_EXIT_LD  = timer_load(EXIT_DLY);
  localparam logic [c_TIMER_W-1:0] c_ENTRY_LD = timer_load(ENTRY_DLY);
  localparam logic [c_TIMER_W-1:0] c_SIREN_LD = timer_load(SIREN_TO);

  state_t               r_state;
  state_t               w_next;
  logic                 w_load;
  logic [c_TIMER_W-1:0] w_load_val;
  logic                 w_expired;
  logic                 w_instant;
  logic                 w_delayed;
  logic [3:0]           r_latched;
  logic                 r_arm_fault;

  assign w_instant = |(Sensor & c_ZONE_INSTANT);
  assign w_delayed = |(Sensor & c_ZONE_DELAYED);

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state <= ST_DISARMED;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_load_val = '0;
    case (r_state)
      ST_DISARMED:    if (Arm_Req && (Sensor == 4'b0000)) w_next = ST_EXIT_DELAY;
      ST_EXIT_DELAY:  if (w_expired) w_next = ST_ARMED;
      ST_ARMED: begin
        if (w_instant)      w_next = ST_ALARM;
        else if (w_delayed) w_next = ST_ENTRY_DELAY;
      end
      ST_ENTRY_DELAY: if (w_instant || w_expired) w_next = ST_ALARM;
      ST_ALARM:       if (w_expired) w_next = ST_ARMED;
      default:        w_next = ST_DISARMED;
    endcase
    // Disarm beats every other event, including a simultaneous arm request.
    if (Disarm_Req) w_next = ST_DISARMED;

    case (w_next)
      ST_EXIT_DELAY:  w_load_val = c_EXIT_LD;
      ST_ENTRY_DELAY: w_load_val = c_ENTRY_LD;
      ST_ALARM:       w_load_val = c_SIREN_LD;
      default:        w_load_val = '0;
    endcase
  end

  assign w_load = (w_next != r_state);

  alarm_timer u_timer (
    .clk        (Clock),
    .rst_n      (Reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_expired  (w_expired)
  );

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_latched   <= '0;
      r_arm_fault <= 1'b0;
    end else begin
      r_arm_fault <= (r_state == ST_DISARMED) && Arm_Req && !Disarm_Req &&
                     (Sensor != 4'b0000);
      if (r_state == ST_DISARMED && w_next == ST_EXIT_DELAY) begin
        r_latched <= '0;
      end else if (r_state == ST_ARMED || r_state == ST_ENTRY_DELAY ||
                   r_state == ST_ALARM) begin
        r_latched <= r_latched | Sensor;
      end
    end
  end

`ifdef ALARM_CHIME_EN
  logic [3:0] r_sensor_q;
  logic       r_chime;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_sensor_q <= '0;
      r_chime    <= 1'b0;
    end else begin
      r_sensor_q <= Sensor;
      r_chime    <= (r_state == ST_DISARMED) && |(Sensor & ~r_sensor_q);
    end
  end

  assign Chime = r_chime;
`endif

  assign State        = r_state;
  assign Armed        = (r_state != ST_DISARMED);
  assign Alarm_State  = (r_state == ST_ALARM);
  assign Latched_Zone = r_latched;
  assign Arm_Fault    = r_arm_fault;

endmodule

`default_nettype wire

// File: tb/tb_alarm_controller.sv
// ============================================================================
// tb_alarm_controller : cycle-level table and sequence checks for
//                       alarm_controller (default parameters).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alarm_controller;

  localparam logic [2:0] DIS   = 3'd0;
  localparam logic [2:0] EXIT  = 3'd1;
  localparam logic [2:0] ARMD  = 3'd2;
  localparam logic [2:0] ENTRY = 3'd3;
  localparam logic [2:0] ALRM  = 3'd4;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] Sensor = 4'b0000;
  logic       Arm_Req = 1'b0;
  logic       Disarm_Req = 1'b0;
  logic       Alarm_State;
  logic       Armed;
  logic [2:0] State;
  logic [3:0] Latched_Zone;
  logic       Arm_Fault;
`ifdef ALARM_CHIME_EN
  logic       Chime;
`endif

  alarm_controller dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .Sensor       (Sensor),
    .Arm_Req      (Arm_Req),
    .Disarm_Req   (Disarm_Req),
    .Alarm_State  (Alarm_State),
    .Armed        (Armed),
    .State        (State),
    .Latched_Zone (Latched_Zone),
    .Arm_Fault    (Arm_Fault)
`ifdef ALARM_CHIME_EN
    ,
    .Chime        (Chime)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [2:0] st;
    logic       fault;
    logic [3:0] lz;
    logic       chime;
  } exp_t;

  typedef struct {
    string      tag;
    logic       rn;
    logic [3:0] s;
    logic       a;
    logic       d;
    logic [2:0] st;
    logic [3:0] lz;
    logic       f;
    logic       ch;
  } vec_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic cyc(input string tag, input logic rn, input logic [3:0] s,
                     input logic a, input logic d, input logic [2:0] st,
                     input logic [3:0] lz, input logic f, input logic ch);
    exp_t       e;
    logic [9:0] act;
    logic [9:0] exp_v;
    @(negedge Clock);
    Reset_n    = rn;
    Sensor     = s;
    Arm_Req    = a;
    Disarm_Req = d;
    e.st = st; e.fault = f; e.lz = lz; e.chime = ch;
    sb_q.push_back(e);
    @(posedge Clock);
    #1;
    e     = sb_q.pop_front();
    act   = {State, Alarm_State, Armed, Arm_Fault, Latched_Zone, 1'b0};
    exp_v = {e.st, (e.st == ALRM), (e.st != DIS), e.fault, e.lz, 1'b0};
`ifdef ALARM_CHIME_EN
    act[0]   = Chime;
    exp_v[0] = e.chime;
`endif
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got {st,alarm,armed,fault,lz,chime}=%b want %b (t=%0t)",
                  tag, act, exp_v, $time);
  endtask

  task automatic hold(input string tag, input int n, input logic [3:0] s,
                      input logic [2:0] st, input logic [3:0] lz);
    for (int i = 0; i < n; i++) cyc(tag, 1'b1, s, 1'b0, 1'b0, st, lz, 1'b0, 1'b0);
  endtask

  task automatic do_arm(input string tag);
    cyc(tag, 1'b1, 4'b0000, 1'b1, 1'b0, EXIT, 4'b0000, 1'b0, 1'b0);
    hold(tag, 15, 4'b0000, EXIT, 4'b0000);
    cyc(tag, 1'b1, 4'b0000, 1'b0, 1'b0, ARMD, 4'b0000, 1'b0, 1'b0);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{"reset0",        1'b0, 4'b0000, 1'b0, 1'b0, DIS, 4'h0, 1'b0, 1'b0};
    tbl[1] = '{"reset1",        1'b0, 4'b0000, 1'b1, 1'b0, DIS, 4'h0, 1'b0, 1'b0};
    tbl[2] = '{"fault_arm",     1'b1, 4'b1000, 1'b1, 1'b0, DIS, 4'h0, 1'b1, 1'b1};
    tbl[3] = '{"fault_end",     1'b1, 4'b1000, 1'b0, 1'b0, DIS, 4'h0, 1'b0, 1'b0};
    tbl[4] = '{"sens_clear",    1'b1, 4'b0000, 1'b0, 1'b0, DIS, 4'h0, 1'b0, 1'b0};
    tbl[5] = '{"arm_dis_same",  1'b1, 4'b0000, 1'b1, 1'b1, DIS, 4'h0, 1'b0, 1'b0};
    tbl[6] = '{"dis_idle",      1'b1, 4'b0000, 1'b0, 1'b1, DIS, 4'h0, 1'b0, 1'b0};
    tbl[7] = '{"fault_instant", 1'b1, 4'b0110, 1'b1, 1'b0, DIS, 4'h0, 1'b1, 1'b1};
    tbl[8] = '{"fault_delayed", 1'b1, 4'b0001, 1'b1, 1'b0, DIS, 4'h0, 1'b1, 1'b1};
    tbl[9] = '{"idle",          1'b1, 4'b0000, 1'b0, 1'b0, DIS, 4'h0, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++)
      cyc(tbl[i].tag, tbl[i].rn, tbl[i].s, tbl[i].a, tbl[i].d,
          tbl[i].st, tbl[i].lz, tbl[i].f, tbl[i].ch);

    // Arm; sensors ignored during exit delay; ARMED after 16 cycles
    cyc("arm", 1'b1, 4'b0000, 1'b1, 1'b0, EXIT, 4'h0, 1'b0, 1'b0);
    hold("exit_ignore", 7, 4'b0010, EXIT, 4'h0);
    hold("exit_wait", 8, 4'b0000, EXIT, 4'h0);
    cyc("exit_done", 1'b1, 4'b0000, 1'b0, 1'b0, ARMD, 4'h0, 1'b0, 1'b0);

    // Entry door -> entry delay 8 -> alarm 64 -> auto re-arm
    cyc("entry", 1'b1, 4'b0001, 1'b0, 1'b0, ENTRY, 4'h1, 1'b0, 1'b0);
    hold("entry_wait", 7, 4'b0000, ENTRY, 4'h1);
    cyc("entry_exp", 1'b1, 4'b0000, 1'b0, 1'b0, ALRM, 4'h1, 1'b0, 1'b0);
    hold("siren", 63, 4'b0000, ALRM, 4'h1);
    cyc("rearm", 1'b1, 4'b0000, 1'b0, 1'b0, ARMD, 4'h1, 1'b0, 1'b0);

    // Re-trip after re-arm: entry timer must reload to the full delay
    cyc("retrip", 1'b1, 4'b0001, 1'b0, 1'b0, ENTRY, 4'h1, 1'b0, 1'b0);
    hold("retrip_wait", 7, 4'b0000, ENTRY, 4'h1);
    cyc("retrip_exp", 1'b1, 4'b0000, 1'b0, 1'b0, ALRM, 4'h1, 1'b0, 1'b0);
    cyc("dis_alarm", 1'b1, 4'b0000, 1'b0, 1'b1, DIS, 4'h1, 1'b0, 1'b0);

    // Instant zone -> alarm; disarm 3 cycles later keeps the latch
    do_arm("arm2");
    cyc("instant", 1'b1, 4'b0100, 1'b0, 1'b0, ALRM, 4'h4, 1'b0, 1'b0);
    hold("alarm_hold", 2, 4'b0000, ALRM, 4'h4);
    cyc("dis_instant", 1'b1, 4'b0000, 1'b0, 1'b1, DIS, 4'h4, 1'b0, 1'b0);

    // Door chime on a rising sensor while disarmed; latch held
    cyc("chime", 1'b1, 4'b0010, 1'b0, 1'b0, DIS, 4'h4, 1'b0, 1'b1);
    hold("chime_hold", 4, 4'b0010, DIS, 4'h4);
    cyc("chime_off", 1'b1, 4'b0000, 1'b0, 1'b0, DIS, 4'h4, 1'b0, 1'b0);

    // Arm+disarm together on the exit-delay expiry cycle
    cyc("arm3", 1'b1, 4'b0000, 1'b1, 1'b0, EXIT, 4'h0, 1'b0, 1'b0);
    hold("exit3", 15, 4'b0000, EXIT, 4'h0);
    cyc("exit_arm_dis", 1'b1, 4'b0000, 1'b1, 1'b1, DIS, 4'h0, 1'b0, 1'b0);

    // Disarm overrides an instant trip during entry delay
    do_arm("arm4");
    cyc("entry4", 1'b1, 4'b0001, 1'b0, 1'b0, ENTRY, 4'h1, 1'b0, 1'b0);
    cyc("dis_vs_instant", 1'b1, 4'b1000, 1'b0, 1'b1, DIS, 4'h9, 1'b0, 1'b0);

    // Reset during alarm silences everything on the next edge
    do_arm("arm5");
    cyc("instant5", 1'b1, 4'b0010, 1'b0, 1'b0, ALRM, 4'h2, 1'b0, 1'b0);
    hold("alarm5", 1, 4'b0000, ALRM, 4'h2);
    cyc("rst_alarm", 1'b0, 4'b0000, 1'b0, 1'b0, DIS, 4'h0, 1'b0, 1'b0);
    cyc("post_rst", 1'b1, 4'b0000, 1'b0, 1'b0, DIS, 4'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 SHALL have parameter EXIT_DLY, default 16, cycles spent in EXIT_DELAY (legal 1..255).
REQ-002 SHALL have parameter ENTRY_DLY, default 8, cycles spent in ENTRY_DELAY (legal 1..255).
REQ-003 SHALL have parameter SIREN_TO, default 64, cycles spent in ALARM before auto-rearm (legal 1..255).
REQ-004 SHALL have ports: Clock  in  1  sole clock, rising edge.
REQ-005 Reset_n  in  1  reset, synchronous, active-low.
REQ-006 Sensor  in  4  HIGH = entry open; bit 0 = delayed entry door, bits 3:1 = instant zones.
REQ-007 Arm_Req  in  1  one-cycle arm request; Disarm_Req  in  1  one-cycle disarm request (valid code already checked upstream).
REQ-008 Alarm_State  out  1  HIGH while siren sounds; Armed  out  1  HIGH in EXIT_DELAY/ARMED/ENTRY_DELAY/ALARM.
REQ-009 State  out  3  current state encoding; Latched_Zone  out  4  zones tripped since last arm; Arm_Fault  out  1  one-cycle pulse.

Function
REQ-010 States SHALL be DISARMED, EXIT_DELAY, ARMED, ENTRY_DELAY, ALARM; outputs Moore-decoded from state register, so every response appears one edge after the triggering input.
REQ-011 DISARMED: Arm_Req with Sensor==0 -> EXIT_DELAY; Arm_Req with Sensor!=0 -> stay, Arm_Fault pulses next cycle.
REQ-012 EXIT_DELAY: sensors ignored; after exactly EXIT_DLY cycles in state -> ARMED.
REQ-013 ARMED: any Sensor[3:1] -> ALARM; else Sensor[0] -> ENTRY_DELAY.
REQ-014 ENTRY_DELAY: any Sensor[3:1] -> ALARM immediately; after exactly ENTRY_DLY cycles in state -> ALARM.
REQ-015 ALARM: Alarm_State=1; after exactly SIREN_TO cycles -> ARMED (Latched_Zone retained).
REQ-016 Disarm_Req in any state other than DISARMED SHALL go to DISARMED next edge, overriding timer expiry and sensor events.
REQ-017 Arm_Req and Disarm_Req together: Disarm wins; Arm_Req outside DISARMED ignored, no Arm_Fault.
REQ-018 Delay timer: 8-bit down-counter loaded with N-1 on state entry, expiry at 0; no wrap; reloads on every entry, including ALARM->ARMED->ENTRY_DELAY re-trips.
REQ-019 Latched_Zone SHALL OR-accumulate Sensor each cycle in ARMED, ENTRY_DELAY, ALARM; hold in DISARMED; clear on entry to EXIT_DELAY.

Reset
REQ-020 Reset_n low at a rising edge: State=DISARMED, Alarm_State=0, Armed=0, Latched_Zone=0, Arm_Fault=0, timer=0, Chime=0; mid-operation reset (incl. during ALARM) SHALL silence siren next edge.

Configuration
REQ-021 Macro ALARM_CHIME_EN defined: extra output Chime (1 bit) pulses one cycle when any Sensor bit rises (0->1, edge-detected via registered Sensor) while DISARMED.
REQ-022 Macro undefined: no Chime port, no edge-detect register; all other behaviour identical.

Structure
REQ-023 Package alarm_pkg SHALL hold state encodings (DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4), timer width (8) and zone masks (DELAYED=4'b0001, INSTANT=4'b1110).
REQ-024 Timer SHALL be sub-module alarm_timer (load, load value, expired flag); FSM and zone latch stay in alarm_controller.

Verification
REQ-025 Reset, Arm_Req, Sensor=0, defaults -> Armed=1 next edge, State=ARMED exactly 16 cycles later, Alarm_State=0.
REQ-026 ARMED, Sensor=4'b0001 for 1 cycle -> ENTRY_DELAY; no Disarm -> ALARM 8 cycles later, Latched_Zone=4'b0001; 64 cycles later State=ARMED.
REQ-027 ARMED, Sensor=4'b0100 -> ALARM next edge; Disarm_Req 3 cycles later -> DISARMED, Alarm_State=0, Latched_Zone=4'b0100 held.
REQ-028 DISARMED, Sensor=4'b1000, Arm_Req -> State stays DISARMED, Arm_Fault=1 for exactly one cycle.
REQ-029 Arm_Req+Disarm_Req same cycle in EXIT_DELAY on expiry cycle -> DISARMED; Reset_n low during ALARM -> all outputs zero next edge.
REQ-030 With ALARM_CHIME_EN, DISARMED, Sensor 0->4'b0010 held 5 cycles -> Chime high exactly one cycle; without macro bench compiles without Chime.
